// File: rtl/face_detect_mul_arb_if.sv
// Request / multiplier / response bundle for face_detect_mul_arb.
//   req_valid/req_a/req_b/req_ready : per-requester operand handshake (16u x 8s)
//   mul_ce/mul_din0/mul_din1/mul_dout : shared multiplier control and data
//   rsp_valid/rsp_id/rsp_data/rsp_ready : tagged product response handshake
//   busy : any operation in flight
// slave = arbiter side, master = requesters/multiplier/consumer side.
interface face_detect_mul_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0]  req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mul_ce;
  logic [15:0]           mul_din0;
  logic [7:0]            mul_din1;
  logic [23:0]           mul_dout;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [23:0]           rsp_data;
  logic                  rsp_ready;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_dout, rsp_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_dout, rsp_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/face_detect_mul_arb.sv
// Round-robin arbiter sharing one pipelined 16u x 8s multiplier among NUM_REQ
// requesters. A tag shadow pipeline ({vld, id} per stage) tracks which
// requester owns each product in flight and advances with mul_ce, so the
// multiplier's own data registers need no reset.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : face_detect_mul_arb_if.slave (requests, multiplier, response, busy)
module face_detect_mul_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned ID_W    = 2
) (
  input logic                  clk,
  input logic                  reset,
  face_detect_mul_arb_if.slave bus
);
  localparam int unsigned A_W = 16;
  localparam int unsigned B_W = 8;

  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic [ID_W-1:0]    id_q [MUL_LAT];
  logic [ID_W-1:0]    id_d [MUL_LAT];
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               mul_ce_c;
  logic               found_lo_c, found_hi_c;
  logic [ID_W-1:0]    idx_lo_c, idx_hi_c;
  logic               grant_vld_c;
  logic [ID_W-1:0]    grant_idx_c;

  logic [A_W-1:0]     a_arr [NUM_REQ];
  logic [B_W-1:0]     b_arr [NUM_REQ];

  // Split the flat operand buses into per-requester lanes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[A_W*g +: A_W];
    assign b_arr[g] = bus.req_b[B_W*g +: B_W];
  end

  // Round-robin pick: lowest valid index at or above ptr wins, otherwise the
  // lowest valid index overall (the wrapped part of the search).
  always_comb begin
    mul_ce_c   = ~(vld_q[MUL_LAT-1] & ~bus.rsp_ready);
    found_lo_c = 1'b0;
    found_hi_c = 1'b0;
    idx_lo_c   = '0;
    idx_hi_c   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found_lo_c = 1'b1;
        idx_lo_c   = ID_W'(i);
        if (ID_W'(i) >= ptr_q) begin
          found_hi_c = 1'b1;
          idx_hi_c   = ID_W'(i);
        end
      end
    end
    grant_idx_c = found_hi_c ? idx_hi_c : idx_lo_c;
    grant_vld_c = found_lo_c & mul_ce_c & ~reset;
  end

  // Tag pipeline shift and pointer advance.
  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    ptr_d = ptr_q;
    if (mul_ce_c) begin
      vld_d[0] = grant_vld_c;
      id_d[0]  = grant_idx_c;
      for (int s = 1; s < int'(MUL_LAT); s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
      end
    end
    if (grant_vld_c) begin
      ptr_d = (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      ptr_q <= '0;
      for (int s = 0; s < int'(MUL_LAT); s++) begin
        id_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
      ptr_q <= ptr_d;
    end
  end

  // Operands are presented in the grant cycle; the multiplier captures them on
  // the same ce edge that loads tag stage 0. Bubbles drive zeros.
  assign bus.mul_ce    = mul_ce_c;
  assign bus.req_ready = grant_vld_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
  assign bus.mul_din0  = grant_vld_c ? a_arr[grant_idx_c] : '0;
  assign bus.mul_din1  = grant_vld_c ? b_arr[grant_idx_c] : '0;

  // Response slot is the last tag stage; data comes straight from the multiplier.
  assign bus.rsp_valid = vld_q[MUL_LAT-1];
  assign bus.rsp_id    = id_q[MUL_LAT-1];
  assign bus.rsp_data  = bus.mul_dout;
  assign bus.busy      = |vld_q;
endmodule
